sigmoid_neuron_pe: RTL and testbench

- Parametrised, pipelined neuron processing element: the next generation of the 4-lane sigmoid ALU.
- Multiplies LANES signed weights by unsigned activations per beat and sums them.
- Accumulates beats until a `last` flag, then adds bias and applies a saturating hard-sigmoid.
- Emits one OUT_WIDTH result per neuron over a valid/ready handshake; sits between the weight/input fetch controller and the layer output buffer.

---
 rtl/sigmoid_pe_pkg.sv | 36 +++
 rtl/sigmoid_pe_adder_tree.sv | 47 ++++
 rtl/sigmoid_neuron_pe.sv | 180 ++++++++++++++++++
 tb/tb_sigmoid_neuron_pe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pe_pkg.sv
// Shared width defaults and arithmetic helpers for the sigmoid neuron processing element.
package sigmoid_pe_pkg;

    localparam int DEF_LANES      = 4;
    localparam int DEF_W_WIDTH    = 4;
    localparam int DEF_X_WIDTH    = 4;
    localparam int DEF_BIAS_WIDTH = 4;
    localparam int DEF_ACC_WIDTH  = 16;
    localparam int DEF_FRAC_SHIFT = 2;
    localparam int DEF_OUT_WIDTH  = 5;

    // Signed weight times zero-extended activation needs one extra bit.
    function automatic int prod_width(input int w_width, input int x_width);
        return w_width + x_width + 1;
    endfunction

    function automatic int sum_width(input int w_width, input int x_width, input int lanes);
        return prod_width(w_width, x_width) + $clog2(lanes);
    endfunction

    // Hard sigmoid: (z >>> 1) recentred on mid-scale, clamped to the output range.
    function automatic logic [31:0] sigmoid_clamp(input logic signed [63:0] z,
                                                  input int out_width);
        logic signed [63:0] y;
        logic signed [63:0] y_max;
        y     = (z >>> 1) + (64'sd1 <<< (out_width - 1));
        y_max = (64'sd1 <<< out_width) - 64'sd1;
        if (y < 0)
            return '0;
        else if (y > y_max)
            return y_max[31:0];
        else
            return y[31:0];
    endfunction

endpackage

// File: rtl/sigmoid_pe_adder_tree.sv
// Registered sign-extending reduction of LANES signed products, with a sideband
// word carried alongside so the caller can keep control bits aligned.
module sigmoid_pe_adder_tree #(
    parameter int LANES     = 4,
    parameter int IN_WIDTH  = 9,
    parameter int SB_WIDTH  = 1,
    parameter int SUM_WIDTH = IN_WIDTH + $clog2(LANES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [LANES*IN_WIDTH-1:0]     in_data,
    input  logic [SB_WIDTH-1:0]           in_sb,
    output logic                          out_valid,
    output logic signed [SUM_WIDTH-1:0]   out_sum,
    output logic [SB_WIDTH-1:0]           out_sb
);

    logic signed [IN_WIDTH-1:0]  lane;
    logic signed [SUM_WIDTH-1:0] sum_next;

    always_comb begin
        lane     = '0;
        sum_next = '0;
        for (int i = 0; i < LANES; i++) begin
            lane     = in_data[i*IN_WIDTH +: IN_WIDTH];
            sum_next = sum_next + SUM_WIDTH'(lane);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_sb    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            out_sum   <= sum_next;
            out_sb    <= in_sb;
        end
    end

endmodule

// File: rtl/sigmoid_neuron_pe.sv
// Pipelined neuron PE: multiply, adder tree, accumulate, bias add and hard sigmoid.
// Build option SIGMOID_PE_ACC_SAT_EN: saturating accumulator plus sticky acc_sat output.
module sigmoid_neuron_pe
    import sigmoid_pe_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int W_WIDTH    = DEF_W_WIDTH,
    parameter int X_WIDTH    = DEF_X_WIDTH,
    parameter int BIAS_WIDTH = DEF_BIAS_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [LANES*W_WIDTH-1:0]    weights,
    input  logic [LANES*X_WIDTH-1:0]    acts,
    input  logic [BIAS_WIDTH-1:0]       bias,
    input  logic                        clear,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out
`ifdef SIGMOID_PE_ACC_SAT_EN
    ,
    output logic                        acc_sat
`endif
);

    localparam int PW = prod_width(W_WIDTH, X_WIDTH);
    localparam int SW = sum_width(W_WIDTH, X_WIDTH, LANES);
    localparam int ZW = ACC_WIDTH + 1;

    logic stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall && !rst;

    logic signed [PW-1:0]  w_ext;
    logic signed [PW-1:0]  a_ext;
    logic signed [PW-1:0]  p_lane;
    logic [LANES*PW-1:0]   prod_next;

    always_comb begin
        w_ext     = '0;
        a_ext     = '0;
        p_lane    = '0;
        prod_next = '0;
        for (int i = 0; i < LANES; i++) begin
            w_ext  = PW'(signed'(weights[i*W_WIDTH +: W_WIDTH]));
            a_ext  = PW'({1'b0, acts[i*X_WIDTH +: X_WIDTH]});
            p_lane = w_ext * a_ext;
            prod_next[i*PW +: PW] = p_lane;
        end
    end

    logic                  s1_valid;
    logic [LANES*PW-1:0]   s1_prod;
    logic                  s1_last;
    logic [BIAS_WIDTH-1:0] s1_bias;

    // A beat offered alongside clear is dropped: clear wins over the capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_last  <= 1'b0;
            s1_bias  <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_prod  <= prod_next;
            s1_last  <= in_last;
            s1_bias  <= bias;
        end
    end

    logic                    s2_valid;
    logic signed [SW-1:0]    s2_sum;
    logic [BIAS_WIDTH:0]     s2_sb;

    sigmoid_pe_adder_tree #(
        .LANES     (LANES),
        .IN_WIDTH  (PW),
        .SB_WIDTH  (BIAS_WIDTH + 1),
        .SUM_WIDTH (SW)
    ) u_adder_tree (
        .clk       (clk),
        .rst       (rst),
        .en        (!stall),
        .flush     (clear),
        .in_valid  (s1_valid),
        .in_data   (s1_prod),
        .in_sb     ({s1_last, s1_bias}),
        .out_valid (s2_valid),
        .out_sum   (s2_sum),
        .out_sb    (s2_sb)
    );

    logic                          s2_last;
    logic signed [BIAS_WIDTH-1:0]  s2_bias;

    assign s2_last = s2_sb[BIAS_WIDTH];
    assign s2_bias = s2_sb[BIAS_WIDTH-1:0];

    logic signed [ACC_WIDTH-1:0] acc;
    logic                        first;
    logic signed [ACC_WIDTH-1:0] sum_ext;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] total;
    logic signed [ACC_WIDTH-1:0] total_shr;
    logic signed [ZW-1:0]        z;
    logic [OUT_WIDTH-1:0]        out_next;

`ifdef SIGMOID_PE_ACC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic signed [ZW-1:0] total_full;
    logic                 total_ovf;
`endif

    always_comb begin
        sum_ext  = ACC_WIDTH'(s2_sum);
        acc_base = first ? '0 : acc;
`ifdef SIGMOID_PE_ACC_SAT_EN
        total_full = ZW'(acc_base) + ZW'(sum_ext);
        total_ovf  = total_full[ACC_WIDTH] != total_full[ACC_WIDTH-1];
        if (total_ovf)
            total = total_full[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else
            total = total_full[ACC_WIDTH-1:0];
`else
        total = acc_base + sum_ext;
`endif
        total_shr = total >>> FRAC_SHIFT;
        z         = ZW'(total_shr) + ZW'(s2_bias);
        out_next  = OUT_WIDTH'(sigmoid_clamp(64'(z), OUT_WIDTH));
    end

    // clear resets the running neuron but leaves a presented result alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
`ifdef SIGMOID_PE_ACC_SAT_EN
            acc_sat   <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (clear) begin
                acc     <= '0;
                first   <= 1'b1;
`ifdef SIGMOID_PE_ACC_SAT_EN
                acc_sat <= 1'b0;
`endif
            end else if (!stall && s2_valid) begin
                if (s2_last) begin
                    out       <= out_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    first     <= 1'b1;
                end else begin
                    acc   <= total;
                    first <= 1'b0;
                end
`ifdef SIGMOID_PE_ACC_SAT_EN
                if (total_ovf)
                    acc_sat <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_neuron_pe.sv
// Scoreboard bench for sigmoid_neuron_pe: directed neurons push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_sigmoid_neuron_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] weights;
    logic [15:0] acts;
    logic [3:0]  bias;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out;
`ifdef SIGMOID_PE_ACC_SAT_EN
    logic        acc_sat;
`endif

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    sigmoid_neuron_pe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .weights   (weights),
        .acts      (acts),
        .bias      (bias),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
`ifdef SIGMOID_PE_ACC_SAT_EN
        ,
        .acc_sat   (acc_sat)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: output handshakes pop the scoreboard; stalled outputs must hold.
    logic       hold_valid = 1'b0;
    logic [4:0] hold_out   = '0;

    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("stall_valid_hold", {31'd0, out_valid}, 32'd1);
                check("stall_out_hold", {27'd0, out}, {27'd0, hold_out});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected none", out);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    check("result", {27'd0, out}, {27'd0, e});
                end
            end
            hold_valid = out_valid && !out_ready;
            hold_out   = out;
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [3:0] w, input logic [3:0] x,
                             input logic l, input logic [3:0] b);
        int  n;
        bit  ok;
        in_valid = 1'b1;
        weights  = {4{w}};
        acts     = {4{x}};
        in_last  = l;
        bias     = b;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        weights   = '0;
        acts      = '0;
        bias      = '0;
        clear     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", {27'd0, out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single-beat neuron: sum 60, z 15, out 23; valid two edges after accept
        exp_q.push_back(5'd23);
        send_beat(4'd1, 4'd15, 1'b1, 4'd0);
        @(negedge clk);
        check("latency_c1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_c2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_c3", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Two-beat neuron (-960 -> 0) then bias-only neuron (z 7 -> 19), no bubble
        exp_q.push_back(5'd0);
        exp_q.push_back(5'd19);
        send_beat(4'h8, 4'd15, 1'b0, 4'd0);
        send_beat(4'h8, 4'd15, 1'b1, 4'd0);
        send_beat(4'h0, 4'd5, 1'b1, 4'd7);
        drain();

        // Backpressure: results 23, 18, 19, 8 while the pipe stalls
        out_ready = 1'b0;
        exp_q.push_back(5'd23);
        exp_q.push_back(5'd18);
        exp_q.push_back(5'd19);
        exp_q.push_back(5'd8);
        fork
            begin
                send_beat(4'd1, 4'd15, 1'b1, 4'd0);
                send_beat(4'd1, 4'd4, 1'b0, 4'd0);
                send_beat(4'd1, 4'd1, 1'b1, 4'd0);
                send_beat(4'd3, 4'd2, 1'b1, 4'd0);
                send_beat(4'hF, 4'd15, 1'b1, 4'd0);
            end
            begin
                wait_out_valid("bp_out_valid");
                check("bp_out_first", {27'd0, out}, 32'd23);
                repeat (4) begin
                    @(negedge clk);
                    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // clear after three partial beats; a last beat offered with clear is dropped
        send_beat(4'h8, 4'd15, 1'b0, 4'd0);
        send_beat(4'h8, 4'd15, 1'b0, 4'd0);
        send_beat(4'h8, 4'd15, 1'b0, 4'd0);
        clear    = 1'b1;
        in_valid = 1'b1;
        weights  = {4{4'h8}};
        acts     = {4{4'hF}};
        in_last  = 1'b1;
        @(negedge clk);
        check("clear_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_q.push_back(5'd23);
        send_beat(4'd1, 4'd15, 1'b1, 4'd0);
        drain();

        // Overflow: 69 beats of -480
`ifdef SIGMOID_PE_ACC_SAT_EN
        exp_q.push_back(5'd0);
`else
        exp_q.push_back(5'd31);
`endif
        for (int i = 0; i < 69; i++)
            send_beat(4'h8, 4'd15, (i == 68), 4'd0);
        drain();
`ifdef SIGMOID_PE_ACC_SAT_EN
        @(negedge clk);
        check("acc_sat_set", {31'd0, acc_sat}, 32'd1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("acc_sat_cleared", {31'd0, acc_sat}, 32'd0);
        @(posedge clk);
        #1;
`endif

        // Reset mid-neuron with a result pending
        out_ready = 1'b0;
        send_beat(4'd1, 4'd15, 1'b1, 4'd0);
        send_beat(4'd7, 4'd15, 1'b0, 4'd0);
        wait_out_valid("rst_pre_valid");
        check("rst_pre_out", {27'd0, out}, 32'd23);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_out", {27'd0, out}, 32'd0);
        @(posedge clk);
        #1;
        // sum 24, z 6 + (-2) = 4, out 18; stale partial beat would saturate to 31
        exp_q.push_back(5'd18);
        send_beat(4'd1, 4'd6, 1'b1, 4'hE);
        drain();

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
